// File: rtl/fir_decim_fifo.sv
// Decimating output stage: removes the FIR x256 coefficient scaling, keeps one
// sample in every DECIM, and buffers kept samples in a valid/ready FIFO.
// Optional build macro FIR_DECIM_ROUND_EN selects round-half-up scaling instead of truncation.
module fir_decim_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SHIFT  = 8,
  parameter int unsigned DECIM  = 4,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_en,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(DEPTH);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] scaled;
  logic [CNT_W-1:0]  dcnt;
  logic [PTR_W-1:0]  wr;
  logic [PTR_W-1:0]  rd;
  logic [PTR_W:0]    count;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              keep;
  logic              full;
  logic              push;
  logic              pop;

  always_comb begin
`ifdef FIR_DECIM_ROUND_EN
    sum = {1'b0, in_data} + ((DATA_W+1)'(1) << (SHIFT - 1));
`else
    sum = {1'b0, in_data};
`endif
    scaled = DATA_W'(sum >> SHIFT);
  end

  always_comb begin
    keep = in_en && (dcnt == DCNT_LAST);
    full = (count == FULL_CNT);
    pop  = (count != '0) && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push = keep && (!full || pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt     <= '0;
      wr       <= '0;
      rd       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_en) dcnt <= keep ? '0 : dcnt + CNT_W'(1);
      if (push)  wr   <= wr + PTR_W'(1);
      if (pop)   rd   <= rd + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (keep && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr] <= scaled;
  end

  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rd] : '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Scoreboard bench for fir_decim_fifo: three instances (DECIM 4, 1, 3) share the
// stimulus; a queue-based reference model predicts each output stream.
module tb_fir_decim_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_en = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] od [3];
  logic        ov [3];
  logic [3:0]  fc [3];
  logic        of [3];

  int total = 0;
  int bad = 0;

  int unsigned acc [3];
  int unsigned occ [3];
  bit          ovf_m [3];
  logic [15:0] exp_q [3][$];

  always #5 clk = ~clk;

  fir_decim_fifo #(.DATA_W(16), .SHIFT(8), .DECIM(4), .DEPTH(8)) u_d4 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_en(in_en),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .fifo_count(fc[0]), .overflow(of[0]));

  fir_decim_fifo #(.DATA_W(16), .SHIFT(8), .DECIM(1), .DEPTH(8)) u_d1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_en(in_en),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .fifo_count(fc[1]), .overflow(of[1]));

  fir_decim_fifo #(.DATA_W(16), .SHIFT(8), .DECIM(3), .DEPTH(8)) u_d3 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_en(in_en),
    .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .fifo_count(fc[2]), .overflow(of[2]));

  function automatic int unsigned dec(int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 3);
  endfunction

  function automatic int unsigned scale(int unsigned d);
`ifdef FIR_DECIM_ROUND_EN
    return (d + 128) / 256;
`else
    return d / 256;
`endif
  endfunction

  task automatic chk(string name, int i, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      acc[i] = 0;
      occ[i] = 0;
      ovf_m[i] = 1'b0;
      exp_q[i].delete();
    end
  endtask

  // Reference model: every DECIM-th accepted input is kept; a kept sample is
  // stored if the FIFO has room or a transfer happens at the same edge.
  always @(posedge clk) begin
    bit keep, pop;
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        pop = (occ[i] != 0) && out_ready;
        keep = 1'b0;
        if (in_en) begin
          acc[i]++;
          keep = (acc[i] % dec(i)) == 0;
        end
        if (keep) begin
          if (occ[i] < 8 || pop) begin
            exp_q[i].push_back(16'(scale(int'(in_data))));
            occ[i]++;
          end else begin
            ovf_m[i] = 1'b1;
          end
        end
        if (pop) occ[i]--;
      end
    end
  end

  // Monitor: checks status every falling edge and retires the head on a transfer.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        chk("rst_valid", i, int'(ov[i]), 0);
        chk("rst_data", i, int'(od[i]), 0);
        chk("rst_count", i, int'(fc[i]), 0);
      end else begin
        chk("count", i, int'(fc[i]), int'(occ[i]));
        chk("overflow", i, int'(of[i]), int'(ovf_m[i]));
        chk("valid", i, int'(ov[i]), int'(occ[i] != 0));
        if (occ[i] == 0) begin
          chk("idle_data", i, int'(od[i]), 0);
        end else if (exp_q[i].size() != 0) begin
          chk("data", i, int'(od[i]), int'(exp_q[i][0]));
          if (out_ready) void'(exp_q[i].pop_front());
        end
      end
    end
  end

  task automatic cyc(bit en, logic [15:0] d, bit rdy);
    in_en = en;
    in_data = d;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between edges and expects every output to clear at once.
  task automatic async_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    in_en = 1'b0;
    out_ready = 1'b0;
    model_clear();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("async_valid", i, int'(ov[i]), 0);
      chk("async_data", i, int'(od[i]), 0);
      chk("async_count", i, int'(fc[i]), 0);
      chk("async_ovf", i, int'(of[i]), 0);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_1f80;

  initial begin
`ifdef FIR_DECIM_ROUND_EN
    exp_1f80 = 16'h0020;
`else
    exp_1f80 = 16'h001F;
`endif
    model_clear();
    #1;
    chk("por_count", 0, int'(fc[0]), 0);
    chk("por_valid", 0, int'(ov[0]), 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Constant input, consumer always ready.
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b1, 16'h1F80, 1'b1);
      if (k == 3) chk("first_early", 0, int'(ov[0]), 0);
      if (k == 4) begin
        chk("first_valid", 0, int'(ov[0]), 1);
        chk("first_data", 0, int'(od[0]), int'(exp_1f80));
      end
      if (k == 5) chk("one_in_four", 0, int'(ov[0]), 0);
    end

    // Overflow: stalled consumer, 10 samples into DECIM=1 instance.
    async_reset();
    for (int k = 1; k <= 10; k++) cyc(1'b1, 16'(k * 256), 1'b0);
    chk("ovf_count", 1, int'(fc[1]), 8);
    chk("ovf_flag", 1, int'(of[1]), 1);
    for (int k = 0; k < 10; k++) cyc(1'b0, 16'h0000, 1'b1);
    chk("ovf_sticky", 1, int'(of[1]), 1);
    for (int k = 0; k < 5; k++) cyc(1'b1, 16'($urandom), 1'b0);
    chk("pre_rst_count", 1, int'(fc[1]), 5);

    // Reset while partly full with overflow set.
    async_reset();

    // Full FIFO with keep and pop at the same edge.
    for (int k = 0; k < 8; k++) cyc(1'b1, 16'($urandom), 1'b0);
    cyc(1'b1, 16'hAB00, 1'b1);
    chk("full_pp_count", 1, int'(fc[1]), 8);
    chk("full_pp_ovf", 1, int'(of[1]), 0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 16'h0000, 1'b1);

    // in_en toggling.
    for (int k = 0; k < 24; k++) cyc(k % 2 == 0, 16'($urandom), 1'b1);

    // Pointer wrap with simultaneous push and pop.
    cyc(1'b1, 16'hFFFF, 1'b1);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 16'($urandom), 1'b1);
      chk("wrap_count", 1, int'(fc[1]), 1);
    end

    // Random traffic.
    for (int k = 0; k < 400; k++)
      cyc(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0);
    for (int k = 0; k < 12; k++) cyc(1'b0, 16'h0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
